// File: rtl/ball_plotter.sv
// ball_plotter: on each motion step, erases the ball's old square with
// BG_COLOUR and then draws the new square with BALL_COLOUR. It emits one
// pixel per clock to the VGA adapter.
//
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   start, erase_en    plot request (sampled only in IDLE); erase_en=0 skips erase
//   old_x/y, new_x/y   previous / updated top-left coordinates (10 bit)
//   vga_x/y/colour     pixel coordinate and colour to the adapter
//   vga_plot           pixel write strobe
//   busy, done         high outside IDLE / one-cycle completion pulse
module ball_plotter #(
    parameter int unsigned BALL_SIZE   = 4,
    parameter logic [2:0]  BG_COLOUR   = 3'b000,
    parameter logic [2:0]  BALL_COLOUR = 3'b111
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       erase_en,
    input  logic [9:0] old_x,
    input  logic [9:0] old_y,
    input  logic [9:0] new_x,
    input  logic [9:0] new_y,
    output logic [9:0] vga_x,
    output logic [9:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CW = 4;
    localparam int unsigned PW = 10;
    localparam logic [CW-1:0] LAST = CW'(BALL_SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ERASE = 2'd1,
        S_DRAW  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_row, r_col, w_row_nxt, w_col_nxt;
    logic [PW-1:0] r_old_x, r_old_y, r_new_x, r_new_y;
    logic          w_latch;

    // State register and pixel counters
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_row   <= '0;
            r_col   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
            r_col   <= w_col_nxt;
        end
    end

    // Coordinates captured at the accepted start edge; inputs may change afterwards
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_old_x <= '0;
            r_old_y <= '0;
            r_new_x <= '0;
            r_new_y <= '0;
        end else if (w_latch) begin
            r_old_x <= old_x;
            r_old_y <= old_y;
            r_new_x <= new_x;
            r_new_y <= new_y;
        end
    end

    // Next-state, counter stepping and output decode
    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_latch     = 1'b0;
        vga_x       = '0;
        vga_y       = '0;
        vga_colour  = '0;
        vga_plot    = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;

        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_latch     = 1'b1;
                    w_row_nxt   = '0;
                    w_col_nxt   = '0;
                    w_state_nxt = erase_en ? S_ERASE : S_DRAW;
                end
            end

            S_ERASE, S_DRAW: begin
                vga_plot = 1'b1;
                if (r_state == S_ERASE) begin
                    vga_x      = r_old_x + PW'(r_col);
                    vga_y      = r_old_y + PW'(r_row);
                    vga_colour = BG_COLOUR;
                end else begin
                    vga_x      = r_new_x + PW'(r_col);
                    vga_y      = r_new_y + PW'(r_row);
                    vga_colour = BALL_COLOUR;
                end

                // Row-major scan; the last pixel ends the pass
                if (r_col == LAST) begin
                    w_col_nxt = '0;
                    if (r_row == LAST) begin
                        w_row_nxt   = '0;
                        w_state_nxt = (r_state == S_ERASE) ? S_DRAW : S_DONE;
                    end else begin
                        w_row_nxt = r_row + CW'(1);
                    end
                end else begin
                    w_col_nxt = r_col + CW'(1);
                end
            end

            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
